// File: rtl/ifetch_prefetch.sv
// Instruction fetch with a DEPTH-entry prefetch queue and valid/ready to decode.
// Redirects resolve at the queue head and flush queued and in-flight fetches.
module ifetch_prefetch #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Instruction,
    output logic [XLEN-1:0] branch_base_addr,
    output logic [XLEN-1:0] link_addr,
    input  logic            Branch,
    input  logic            nBranch,
    input  logic            Jmp,
    input  logic            Jal,
    input  logic            Jr,
    input  logic            Zero,
    input  logic [XLEN-1:0] Addr_result,
    input  logic [XLEN-1:0] Read_data_1
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    logic [XLEN-1:0] r_q_pc    [DEPTH];
    logic [XLEN-1:0] r_q_instr [DEPTH];
    logic [AW-1:0]   r_rptr;
    logic [AW-1:0]   r_wptr;
    logic [CW-1:0]   r_count;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_pc;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_link;

    logic            w_empty;
    logic            w_fire;
    logic            w_taken;
    logic            w_push;
    logic            w_issue;
    logic [CW-1:0]   w_occ;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_instr;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_target;

    assign w_empty      = (r_count == '0);
    assign w_head_pc    = r_q_pc[r_rptr];
    assign w_head_instr = r_q_instr[r_rptr];
    assign w_pc4        = w_head_pc + XLEN'(4);
    assign w_fire       = ~w_empty & out_ready;

    assign w_taken = w_fire & ((Branch & Zero) | (nBranch & ~Zero)
                             | Jmp | Jal | Jr);

    // Slots committed after this edge; an in-flight fetch already owns one.
    assign w_occ   = r_count + CW'(r_inflight) - CW'(w_fire);
    assign w_issue = ~w_taken & (w_occ < CW'(DEPTH));

    // A response arriving in a redirect cycle is the killed one.
    assign w_push = r_inflight & ~w_taken;

    always_comb begin
        w_target = Addr_result;
        if (Jr)
            w_target = Read_data_1;
        else if (Jmp | Jal)
            w_target = {w_pc4[XLEN-1:28], w_head_instr[25:0], 2'b00};
        else
            w_target = Addr_result;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rptr        <= '0;
            r_wptr        <= '0;
            r_count       <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_fetch_pc    <= RESET_PC;
            r_link        <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_taken) begin
                r_rptr     <= '0;
                r_wptr     <= '0;
                r_count    <= '0;
                r_fetch_pc <= w_target;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + AW'(1);
                if (w_fire)
                    r_rptr <= r_rptr + AW'(1);
                case ({w_push, w_fire})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
                if (w_issue) begin
                    r_inflight_pc <= r_fetch_pc;
                    r_fetch_pc    <= r_fetch_pc + XLEN'(4);
                end
            end
            if (w_fire && Jal)
                r_link <= w_pc4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && w_push) begin
            r_q_pc[r_wptr]    <= r_inflight_pc;
            r_q_instr[r_wptr] <= imem_rdata;
        end
    end

    assign imem_req         = w_issue;
    assign imem_addr        = r_fetch_pc;
    assign out_valid        = ~w_empty;
    assign Instruction      = w_empty ? '0 : w_head_instr;
    assign branch_base_addr = w_empty ? '0 : w_pc4;
    assign link_addr        = r_link;

endmodule
